study_score: RTL and testbench
==============================

STUDY_SCORE -- requirements
Module: study_score

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on posedge clk.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: en  in  1  study mode active; low = synchronous return to IDLE with all counters cleared.
REQ-004 SHALL have ports: song_start  in  1  one-cycle pulse; begin a new scoring run.
REQ-005 SHALL have ports: song_end  in  1  one-cycle pulse; last goal note finished.
REQ-006 SHALL have ports: hit  in  1  one-cycle pulse; learner completed a note (Pulse-conditioned upstream).
REQ-007 SHALL have ports: octave / note / length  in  OCTAVE_BITS(3) / NOTE_BITS(3) / LENGTH_BITS(3)  played note.
REQ-008 SHALL have ports: goal_octave / goal_note / goal_length  in  3 / 3 / 3  current Song target.
REQ-009 SHALL have ports: judge  out  2  last verdict (0 miss, 1 pitch-only, 2 perfect).
REQ-010 SHALL have ports: judge_valid  out  1  one-cycle pulse with new judge.
REQ-011 SHALL have ports: score  out  8  accumulated points; note_cnt  out  6  judged notes.
REQ-012 SHALL have ports: combo / best_combo  out  6 / 6  current and best consecutive non-miss run.
REQ-013 SHALL have ports: grade  out  2  (3 S, 2 A, 1 B, 0 C); result_valid  out  1  high while in DONE.

Function
REQ-014 SHALL implement FSM IDLE, WAIT_HIT, JUDGE, DONE; reset/en-low state IDLE.
REQ-015 SHALL go IDLE->WAIT_HIT on song_start, clearing score, note_cnt, combo, best_combo, judge.
REQ-016 SHALL latch played and goal fields on hit in WAIT_HIT and go to JUDGE next cycle.
REQ-017 SHALL in JUDGE compute verdict: note, octave and length equal = 2; note and octave equal, length differs = 1; else 0; rest (note==0) vs goal rest counts as pitch match.
REQ-018 SHALL register judge and pulse judge_valid on the cycle after JUDGE (hit-to-judge_valid latency 2 cycles), then return to WAIT_HIT.
REQ-019 SHALL add verdict to score, saturating at 255; increment note_cnt, saturating at 63.
REQ-020 SHALL increment combo on verdict>0 (saturate 63), clear it on 0; best_combo = max(best_combo, new combo).
REQ-021 SHALL ignore hit outside WAIT_HIT (no queueing).
REQ-022 SHALL on song_end in WAIT_HIT go to DONE; song_end coincident with hit: hit judged first, DONE entered after judge_valid.
REQ-023 SHALL in DONE register grade once: max = 2*note_cnt (7-bit); S if note_cnt>0 and score==max; else A if 4*score >= 3*max; else B if 2*score >= max; else C; note_cnt==0 gives C.
REQ-024 SHALL hold all outputs in DONE until song_start (restart) or en low.
REQ-025 SHALL treat song_start in any state as a restart to WAIT_HIT with counters cleared, overriding hit/song_end.

Reset
REQ-026 SHALL on rst_n low force IDLE, all outputs 0, latched fields 0, regardless of state, including mid-JUDGE.
REQ-027 SHALL leave IDLE only on song_start after rst_n release.

Configuration
REQ-028 SHALL compile combo tracking only when STUDY_SCORE_COMBO_EN is defined; undefined: combo and best_combo tied to 0, no combo registers, all other behaviour unchanged.

Structure
REQ-029 SHALL take OCTAVE_BITS, NOTE_BITS, LENGTH_BITS, verdict codes, grade codes and FSM state encodings from Constants.vh.
REQ-030 SHALL place grade computation in a combinational sub-module grade_calc (score, note_cnt -> grade).

Verification
REQ-031 SHALL cover: song_start, 3 perfect hits, song_end -> score 6, note_cnt 3, combo 3, grade 3, result_valid 1.
REQ-032 SHALL cover: hit note 5 oct 4 len 2 vs goal 5/4/3 -> judge 1 exactly 2 cycles after hit, combo +1.
REQ-033 SHALL cover: 2 perfect, 1 miss, 1 perfect -> combo 1, best_combo 2, score 6, max 8, grade 2.
REQ-034 SHALL cover: 200 perfect hits -> score holds 255, note_cnt holds 63.
REQ-035 SHALL cover: hit and song_end same cycle -> judge_valid pulse then result_valid; rst_n low in JUDGE -> all outputs 0 next edge, no judge_valid.
REQ-036 SHALL cover: build without STUDY_SCORE_COMBO_EN, rerun REQ-033 -> combo/best_combo 0, score 6, grade 2.

Source files
------------

// File: rtl/study_score_pkg.sv
// -----------------------------------------------------------------------------
// study_score_pkg
// Shared constants and types for the study-mode scoring block: field widths of
// a played/goal note, verdict codes, grade codes and FSM state encodings, plus
// the note-judging rule used by the top level.
// -----------------------------------------------------------------------------
package study_score_pkg;

  localparam int OCTAVE_BITS = 3;
  localparam int NOTE_BITS   = 3;
  localparam int LENGTH_BITS = 3;
  localparam int SCORE_BITS  = 8;
  localparam int CNT_BITS    = 6;

  // A note value of zero is a rest; rests carry no meaningful octave.
  localparam logic [NOTE_BITS-1:0] REST = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_HIT = 2'd1,
    JUDGE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    VERDICT_MISS    = 2'd0,
    VERDICT_PITCH   = 2'd1,
    VERDICT_PERFECT = 2'd2
  } verdict_t;

  typedef enum logic [1:0] {
    GRADE_C = 2'd0,
    GRADE_B = 2'd1,
    GRADE_A = 2'd2,
    GRADE_S = 2'd3
  } grade_t;

  typedef struct packed {
    logic [OCTAVE_BITS-1:0] octave;
    logic [NOTE_BITS-1:0]   note;
    logic [LENGTH_BITS-1:0] len;
  } note_t;

  // Pitch matches when note and octave agree; two rests match regardless of
  // octave. Length only upgrades a pitch match to perfect.
  function automatic verdict_t judge_note(input note_t played, input note_t goal);
    logic pitch_match;
    pitch_match = (played.note == goal.note) &&
                  ((played.note == REST) || (played.octave == goal.octave));
    if (!pitch_match)
      return VERDICT_MISS;
    else if (played.len == goal.len)
      return VERDICT_PERFECT;
    else
      return VERDICT_PITCH;
  endfunction

endpackage

// File: rtl/study_score_grade_calc.sv
// -----------------------------------------------------------------------------
// grade_calc
// Combinational grade from the accumulated score and number of judged notes.
// The best achievable score is two points per note.
//   score    in  8  accumulated points
//   note_cnt in  6  judged notes
//   grade    out 2  3 S (flawless), 2 A (>=75%), 1 B (>=50%), 0 C
// An empty run always grades C.
// -----------------------------------------------------------------------------
module grade_calc
  import study_score_pkg::*;
(
  input  logic [SCORE_BITS-1:0] score,
  input  logic [CNT_BITS-1:0]   note_cnt,
  output grade_t                grade
);

  logic [CNT_BITS:0] max_score;
  logic [9:0]        score_x4;
  logic [9:0]        score_x2;
  logic [9:0]        max_x3;
  logic [9:0]        max_x1;

  assign max_score = {note_cnt, 1'b0};
  assign score_x4  = {score, 2'b00};
  assign score_x2  = {1'b0, score, 1'b0};
  assign max_x1    = 10'(max_score);
  assign max_x3    = 10'({max_score, 1'b0}) + 10'(max_score);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else chain can infer a latch.
  always_comb begin
    grade = GRADE_C;
    if (note_cnt == '0)
      grade = GRADE_C;
    else if (score == SCORE_BITS'(max_score))
      grade = GRADE_S;
    else if (score_x4 >= max_x3)
      grade = GRADE_A;
    else if (score_x2 >= max_x1)
      grade = GRADE_B;
  end

endmodule

// File: rtl/study_score.sv
// -----------------------------------------------------------------------------
// study_score
// Scores a learner playing along with a song in study mode. Each hit latches
// the played and goal note, is judged one cycle later and the verdict is
// published (judge/judge_valid) the cycle after that. At song end a grade is
// registered and held until the next song_start or en low.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   en                             study mode enable; low returns to IDLE, cleared
//   song_start / song_end / hit    one-cycle control pulses
//   octave / note / length         played note
//   goal_octave/goal_note/goal_length  current target note
//   judge, judge_valid             last verdict and its one-cycle strobe
//   score, note_cnt                accumulated points / judged notes (saturating)
//   combo, best_combo              current / best non-miss run (saturating)
//   grade, result_valid            final grade, valid while in DONE
//
// Build option: define STUDY_SCORE_COMBO_EN to include combo tracking;
// otherwise combo and best_combo are constant zero.
// -----------------------------------------------------------------------------
module study_score
  import study_score_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   song_start,
  input  logic                   song_end,
  input  logic                   hit,
  input  logic [OCTAVE_BITS-1:0] octave,
  input  logic [NOTE_BITS-1:0]   note,
  input  logic [LENGTH_BITS-1:0] length,
  input  logic [OCTAVE_BITS-1:0] goal_octave,
  input  logic [NOTE_BITS-1:0]   goal_note,
  input  logic [LENGTH_BITS-1:0] goal_length,
  output logic [1:0]             judge,
  output logic                   judge_valid,
  output logic [SCORE_BITS-1:0]  score,
  output logic [CNT_BITS-1:0]    note_cnt,
  output logic [CNT_BITS-1:0]    combo,
  output logic [CNT_BITS-1:0]    best_combo,
  output logic [1:0]             grade,
  output logic                   result_valid
);

  state_t   state, next_state;
  note_t    played_q, goal_q;
  logic     end_pending;     // song_end arrived together with the hit being judged
  logic     clear;
  logic     latch_en;
  logic     judge_en;
  logic     grade_en;
  verdict_t verdict;
  grade_t   grade_next;
  logic [SCORE_BITS:0] score_sum;

  assign verdict      = judge_note(played_q, goal_q);
  assign score_sum    = {1'b0, score} + (SCORE_BITS + 1)'(verdict);
  assign result_valid = (state == DONE);

  grade_calc u_grade_calc (
    .score    (score),
    .note_cnt (note_cnt),
    .grade    (grade_next)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    latch_en   = 1'b0;
    judge_en   = 1'b0;
    grade_en   = 1'b0;
    if (!en) begin
      next_state = IDLE;
      clear      = 1'b1;
    end else if (song_start) begin
      // Restart wins over any hit or song_end in the same cycle.
      next_state = WAIT_HIT;
      clear      = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        WAIT_HIT: begin
          if (end_pending) begin
            next_state = DONE;
            grade_en   = 1'b1;
          end else if (hit) begin
            next_state = JUDGE;
            latch_en   = 1'b1;
          end else if (song_end) begin
            next_state = DONE;
            grade_en   = 1'b1;
          end
        end
        JUDGE: begin
          next_state = WAIT_HIT;
          judge_en   = 1'b1;
        end
        DONE: ;
        default: next_state = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      played_q    <= '0;
      goal_q      <= '0;
      end_pending <= 1'b0;
      judge       <= '0;
      judge_valid <= 1'b0;
      score       <= '0;
      note_cnt    <= '0;
      grade       <= '0;
    end else begin
      judge_valid <= 1'b0;
      if (clear) begin
        played_q    <= '0;
        goal_q      <= '0;
        end_pending <= 1'b0;
        judge       <= '0;
        score       <= '0;
        note_cnt    <= '0;
        grade       <= '0;
      end else begin
        if (latch_en) begin
          played_q    <= '{octave: octave, note: note, len: length};
          goal_q      <= '{octave: goal_octave, note: goal_note, len: goal_length};
          end_pending <= song_end;
        end
        if (judge_en) begin
          judge       <= verdict;
          judge_valid <= 1'b1;
          score       <= score_sum[SCORE_BITS] ? '1 : score_sum[SCORE_BITS-1:0];
          if (note_cnt != '1)
            note_cnt <= note_cnt + 1'b1;
        end
        if (grade_en) begin
          grade       <= grade_next;
          end_pending <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combo tracking
  // ---------------------------------------------------------------------------
`ifdef STUDY_SCORE_COMBO_EN
  logic [CNT_BITS-1:0] combo_next;

  always_comb begin
    combo_next = combo;
    if (verdict == VERDICT_MISS)
      combo_next = '0;
    else if (combo != '1)
      combo_next = combo + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      combo      <= '0;
      best_combo <= '0;
    end else if (clear) begin
      combo      <= '0;
      best_combo <= '0;
    end else if (judge_en) begin
      combo <= combo_next;
      if (combo_next > best_combo)
        best_combo <= combo_next;
    end
  end
`else
  assign combo      = '0;
  assign best_combo = '0;
`endif

endmodule

// File: tb/tb_study_score.sv
// -----------------------------------------------------------------------------
// tb_study_score
// Directed and randomized stimulus for study_score with a behavioural scoring
// model. Combo expectations follow the STUDY_SCORE_COMBO_EN build option.
// -----------------------------------------------------------------------------
module tb_study_score;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       song_start;
  logic       song_end;
  logic       hit;
  logic [2:0] octave, note, length;
  logic [2:0] goal_octave, goal_note, goal_length;
  logic [1:0] judge;
  logic       judge_valid;
  logic [7:0] score;
  logic [5:0] note_cnt;
  logic [5:0] combo;
  logic [5:0] best_combo;
  logic [1:0] grade;
  logic       result_valid;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model of the scoring run.
  int m_score, m_cnt, m_combo, m_best, m_judge;

  study_score dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .song_start   (song_start),
    .song_end     (song_end),
    .hit          (hit),
    .octave       (octave),
    .note         (note),
    .length       (length),
    .goal_octave  (goal_octave),
    .goal_note    (goal_note),
    .goal_length  (goal_length),
    .judge        (judge),
    .judge_valid  (judge_valid),
    .score        (score),
    .note_cnt     (note_cnt),
    .combo        (combo),
    .best_combo   (best_combo),
    .grade        (grade),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int ref_verdict(input int o, n, l, go, gn, gl);
    bit same_pitch;
    same_pitch = (n == gn) && (n == 0 || o == go);
    if (!same_pitch) return 0;
    return (l == gl) ? 2 : 1;
  endfunction

  function automatic int ref_grade(input int s, c);
    int best;
    best = 2 * c;
    if (c == 0)            return 0;
    if (s == best)         return 3;
    if (4 * s >= 3 * best) return 2;
    if (2 * s >= best)     return 1;
    return 0;
  endfunction

  function automatic int exp_combo(input int v);
`ifdef STUDY_SCORE_COMBO_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_clear();
    m_score = 0; m_cnt = 0; m_combo = 0; m_best = 0; m_judge = 0;
  endtask

  task automatic model_note(input int v);
    m_judge = v;
    m_score = (m_score + v > 255) ? 255 : m_score + v;
    m_cnt   = (m_cnt == 63) ? 63 : m_cnt + 1;
    if (v == 0) m_combo = 0;
    else if (m_combo < 63) m_combo = m_combo + 1;
    if (m_combo > m_best) m_best = m_combo;
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".judge"},      judge,      m_judge);
    check({tag, ".score"},      score,      m_score);
    check({tag, ".note_cnt"},   note_cnt,   m_cnt);
    check({tag, ".combo"},      combo,      exp_combo(m_combo));
    check({tag, ".best_combo"}, best_combo, exp_combo(m_best));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".judge"},        judge,        0);
    check({tag, ".judge_valid"},  judge_valid,  0);
    check({tag, ".score"},        score,        0);
    check({tag, ".note_cnt"},     note_cnt,     0);
    check({tag, ".combo"},        combo,        0);
    check({tag, ".best_combo"},   best_combo,   0);
    check({tag, ".grade"},        grade,        0);
    check({tag, ".result_valid"}, result_valid, 0);
  endtask

  task automatic start_song(input string tag);
    @(negedge clk) song_start = 1'b1;
    @(negedge clk) song_start = 1'b0;
    model_clear();
    check({tag, ".start_score"}, score, 0);
    check({tag, ".start_cnt"},   note_cnt, 0);
    check({tag, ".start_rv"},    result_valid, 0);
  endtask

  // One judged note. with_end raises song_end together with the hit; extra
  // raises a stray hit while the note is being judged, which must be ignored.
  task automatic play(input string tag, input int o, n, l, go, gn, gl,
                      input bit with_end = 1'b0, input bit extra = 1'b0,
                      input bit quiet = 1'b0);
    int v;
    @(negedge clk);
    hit = 1'b1; song_end = with_end;
    octave = o[2:0]; note = n[2:0]; length = l[2:0];
    goal_octave = go[2:0]; goal_note = gn[2:0]; goal_length = gl[2:0];
    @(negedge clk);
    hit = extra; song_end = 1'b0;
    octave = 3'($urandom); note = 3'($urandom); length = 3'($urandom);
    if (!quiet) check({tag, ".lat1_valid"}, judge_valid, 0);
    @(negedge clk);
    hit = 1'b0;
    v = ref_verdict(o, n, l, go, gn, gl);
    model_note(v);
    check({tag, ".judge_valid"}, judge_valid, 1);
    check({tag, ".judge"},       judge,       v);
    if (!quiet) begin
      check_counts(tag);
      check({tag, ".rv_during_judge"}, result_valid, 0);
    end
  endtask

  task automatic play_random(input string tag);
    int go, gn, gl, o, n, l;
    go = $urandom_range(0, 7); gn = $urandom_range(0, 7); gl = $urandom_range(0, 7);
    o = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : go;
    n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : gn;
    l = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : gl;
    if ($urandom_range(0, 5) == 0) begin n = 0; gn = 0; end
    play(tag, o, n, l, go, gn, gl, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic end_song(input string tag);
    @(negedge clk) song_end = 1'b1;
    @(negedge clk) song_end = 1'b0;
    check({tag, ".result_valid"}, result_valid, 1);
    check({tag, ".grade"},        grade,        ref_grade(m_score, m_cnt));
    check_counts(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; song_start = 1'b0; song_end = 1'b0; hit = 1'b0;
    octave = '0; note = '0; length = '0;
    goal_octave = '0; goal_note = '0; goal_length = '0;
    model_clear();

    // Reset state, then IDLE must ignore hit and song_end.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk) begin hit = 1'b1; song_end = 1'b1; end
    @(negedge clk) begin hit = 1'b0; song_end = 1'b0; end
    @(negedge clk);
    check_zero("idle_ignore");

    // Three perfect notes give a flawless S.
    start_song("s3");
    for (int i = 0; i < 3; i++) play("s3_hit", 4, 5, 2, 4, 5, 2);
    end_song("s3");

    // DONE holds its outputs against stray hits and song_end.
    @(negedge clk) hit = 1'b1;
    @(negedge clk) begin hit = 1'b0; song_end = 1'b1; end
    @(negedge clk) song_end = 1'b0;
    repeat (2) @(negedge clk);
    check("hold.judge_valid",  judge_valid,  0);
    check("hold.result_valid", result_valid, 1);
    check("hold.grade",        grade,        3);
    check_counts("hold");

    // Pitch-only match: length differs.
    start_song("pitch");
    play("pitch", 4, 5, 2, 4, 5, 3);

    // Perfect, perfect, miss, perfect: 6 of 8 points grades A.
    start_song("mix");
    play("mix1", 1, 3, 4, 1, 3, 4);
    play("mix2", 2, 6, 1, 2, 6, 1);
    play("mix3", 2, 6, 1, 3, 6, 1);
    play("mix4", 7, 7, 7, 7, 7, 7);
    end_song("mix");

    // Score saturates at 255 and note_cnt at 63.
    start_song("sat");
    for (int i = 0; i < 200; i++) play("sat_hit", 3, 2, 1, 3, 2, 1, 1'b0, 1'b0, 1'b1);
    check_counts("sat");
    end_song("sat");

    // Rests match each other whatever the octave.
    start_song("rest");
    play("rest1", 2, 0, 5, 6, 0, 5);
    play("rest2", 2, 0, 5, 2, 1, 5);

    // hit together with song_end: judged first, DONE afterwards.
    play("coinc", 5, 4, 3, 5, 4, 3, 1'b1);
    @(negedge clk);
    check("coinc.judge_valid_drop", judge_valid,  0);
    check("coinc.result_valid",     result_valid, 1);
    check("coinc.grade",            grade,        ref_grade(m_score, m_cnt));

    // Randomized song.
    start_song("rnd");
    for (int i = 0; i < 40; i++) play_random("rnd");
    end_song("rnd");

    // song_start in the same cycle as hit restarts and drops the hit.
    @(negedge clk) begin song_start = 1'b1; hit = 1'b1; end
    @(negedge clk) begin song_start = 1'b0; hit = 1'b0; end
    model_clear();
    @(negedge clk);
    check("restart_hit.judge_valid", judge_valid, 0);
    check("restart_hit.note_cnt",    note_cnt,    0);

    // en low clears everything and parks in IDLE.
    play("en", 1, 1, 1, 1, 1, 1);
    @(negedge clk) en = 1'b0;
    @(negedge clk) en = 1'b1;
    model_clear();
    check_zero("en_low");
    @(negedge clk) song_end = 1'b1;
    @(negedge clk) song_end = 1'b0;
    check("en_idle.result_valid", result_valid, 0);

    // Reset asserted while a note is in JUDGE.
    start_song("rstj");
    play("rstj_pre", 1, 2, 3, 1, 2, 3);
    @(negedge clk) begin
      hit = 1'b1; octave = 3'd1; note = 3'd2; length = 3'd3;
      goal_octave = 3'd1; goal_note = 3'd2; goal_length = 3'd3;
    end
    @(negedge clk) begin hit = 1'b0; rst_n = 1'b0; end
    model_clear();
    @(negedge clk);
    check_zero("rst_judge");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    @(negedge clk);
    check_zero("rst_release_idle");

    // Empty song grades C.
    start_song("empty");
    end_song("empty");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
